tx_wr_sequencer: RTL and testbench

Job-level write sequencer that sits directly upstream of the AFU I/O block's TX_WR request port (cor_tx_wr_* / cor_tx_fence_valid / cor_tx_done_valid). It accepts a write job (cache-line address plus length) and a stream of 512-bit data lines, and emits one cache-line write beat per line with incrementing addresses. It honours spl_tx_wr_almostfull, then optionally closes the job with a write fence and a completion ("done") write to the DSM.

---
 rtl/tx_wr_sequencer.sv | 138 +++++++++++++
 tb/tb_tx_wr_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_wr_sequencer.sv
// Job-level write sequencer feeding the TX_WR request port: one beat per data line,
// optionally followed by a write fence and a completion record to the DSM.
module tx_wr_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             spl_reset,
    input  logic             spl_tx_wr_almostfull,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [57:0]      job_addr,
    input  logic [5:0]       job_len,
    input  logic             job_done_en,
    input  logic             dat_valid,
    output logic             dat_ready,
    input  logic [511:0]     dat_data,
    input  logic [63:0]      dsm_base_addr,
    output logic             cor_tx_wr_valid,
    output logic             cor_tx_dsr_valid,
    output logic             cor_tx_fence_valid,
    output logic             cor_tx_done_valid,
    output logic [57:0]      cor_tx_wr_addr,
    output logic [5:0]       cor_tx_wr_len,
    output logic [511:0]     cor_tx_data,
    output logic             busy,
    output logic [CNT_W-1:0] job_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_FENCE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state;
    logic [57:0]      addr_q;
    logic [5:0]       len_q;
    logic             done_en_q;
    logic [5:0]       beat_cnt;
    logic             job_accept;
    logic             dat_fire;
    logic             last_beat;
    logic [CNT_W-1:0] job_cnt_inc;
    logic [511:0]     done_payload;
    logic             unused_dsm_hi;

    assign job_ready        = (state == ST_IDLE);
    assign dat_ready        = (state == ST_DATA) & ~spl_tx_wr_almostfull;
    assign busy             = (state != ST_IDLE);
    assign cor_tx_dsr_valid = 1'b0;

    assign job_accept   = job_valid & job_ready;
    assign dat_fire     = dat_valid & dat_ready;
    assign last_beat    = (beat_cnt == (len_q - 6'd1));
    assign job_cnt_inc  = job_cnt + CNT_W'(1);
    // The done record carries the count this job will complete as, not the old one.
    assign done_payload = {{(512 - CNT_W){1'b0}}, job_cnt_inc};
    assign unused_dsm_hi = ^dsm_base_addr[63:58];

    always_ff @(posedge clk or posedge spl_reset) begin
        if (spl_reset) begin
            state              <= ST_IDLE;
            addr_q             <= '0;
            len_q              <= '0;
            done_en_q          <= 1'b0;
            beat_cnt           <= '0;
            job_cnt            <= '0;
            cor_tx_wr_valid    <= 1'b0;
            cor_tx_fence_valid <= 1'b0;
            cor_tx_done_valid  <= 1'b0;
            cor_tx_wr_addr     <= '0;
            cor_tx_wr_len      <= '0;
            cor_tx_data        <= '0;
        end else begin
            // Strobes are single-cycle; payload fields hold their last value.
            cor_tx_wr_valid    <= 1'b0;
            cor_tx_fence_valid <= 1'b0;
            cor_tx_done_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (job_accept) begin
                        addr_q    <= job_addr;
                        len_q     <= job_len;
                        done_en_q <= job_done_en;
                        beat_cnt  <= '0;
                        if (job_len != 6'd0) begin
                            state <= ST_DATA;
                        end else if (job_done_en) begin
                            state <= ST_FENCE;
                        end else begin
                            job_cnt <= job_cnt_inc;
                        end
                    end
                end
                ST_DATA: begin
                    if (dat_fire) begin
                        cor_tx_wr_valid <= 1'b1;
                        cor_tx_wr_addr  <= addr_q + {52'd0, beat_cnt};
                        cor_tx_wr_len   <= len_q;
                        cor_tx_data     <= dat_data;
                        beat_cnt        <= beat_cnt + 6'd1;
                        if (last_beat) begin
                            if (done_en_q) begin
                                state <= ST_FENCE;
                            end else begin
                                job_cnt <= job_cnt_inc;
                                state   <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_FENCE: begin
                    if (!spl_tx_wr_almostfull) begin
                        cor_tx_wr_valid    <= 1'b1;
                        cor_tx_fence_valid <= 1'b1;
                        cor_tx_wr_addr     <= '0;
                        cor_tx_wr_len      <= 6'd1;
                        cor_tx_data        <= '0;
                        state              <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // dsm_base_addr is taken here so software may move the DSM mid-job.
                    if (!spl_tx_wr_almostfull) begin
                        cor_tx_wr_valid   <= 1'b1;
                        cor_tx_done_valid <= 1'b1;
                        cor_tx_wr_addr    <= dsm_base_addr[57:0];
                        cor_tx_wr_len     <= 6'd1;
                        cor_tx_data       <= done_payload;
                        job_cnt           <= job_cnt_inc;
                        state             <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_wr_sequencer.sv
// Self-checking bench for tx_wr_sequencer: table-driven jobs, hand-written reset and
// back-to-back sequences, then randomized jobs checked against a job-level beat model.
module tb_tx_wr_sequencer;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             spl_reset;
    logic             spl_tx_wr_almostfull;
    logic             job_valid;
    logic             job_ready;
    logic [57:0]      job_addr;
    logic [5:0]       job_len;
    logic             job_done_en;
    logic             dat_valid;
    logic             dat_ready;
    logic [511:0]     dat_data;
    logic [63:0]      dsm_base_addr;
    logic             cor_tx_wr_valid;
    logic             cor_tx_dsr_valid;
    logic             cor_tx_fence_valid;
    logic             cor_tx_done_valid;
    logic [57:0]      cor_tx_wr_addr;
    logic [5:0]       cor_tx_wr_len;
    logic [511:0]     cor_tx_data;
    logic             busy;
    logic [CNT_W-1:0] job_cnt;

    tx_wr_sequencer #(.CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .spl_reset            (spl_reset),
        .spl_tx_wr_almostfull (spl_tx_wr_almostfull),
        .job_valid            (job_valid),
        .job_ready            (job_ready),
        .job_addr             (job_addr),
        .job_len              (job_len),
        .job_done_en          (job_done_en),
        .dat_valid            (dat_valid),
        .dat_ready            (dat_ready),
        .dat_data             (dat_data),
        .dsm_base_addr        (dsm_base_addr),
        .cor_tx_wr_valid      (cor_tx_wr_valid),
        .cor_tx_dsr_valid     (cor_tx_dsr_valid),
        .cor_tx_fence_valid   (cor_tx_fence_valid),
        .cor_tx_done_valid    (cor_tx_done_valid),
        .cor_tx_wr_addr       (cor_tx_wr_addr),
        .cor_tx_wr_len        (cor_tx_wr_len),
        .cor_tx_data          (cor_tx_data),
        .busy                 (busy),
        .job_cnt              (job_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         fence;
        logic         done;
        logic [57:0]  addr;
        logic [5:0]   len;
        logic [511:0] data;
        int           cyc;
    } beat_t;

    typedef struct {
        logic [57:0] addr;
        logic [5:0]  len;
        logic        done_en;
        int          stall_after;
        int          stall_len;
        logic [63:0] dsm;
        int          exp_beats;
        int          exp_cnt;
    } job_vec_t;

    beat_t       obs_q[$];
    beat_t       exp_q[$];
    job_vec_t    tbl[8];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] model_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    // Every issued beat is captured mid-cycle together with the cycle it was visible in.
    always @(negedge clk) begin
        beat_t b;
        if (!spl_reset && cor_tx_wr_valid) begin
            b.fence = cor_tx_fence_valid;
            b.done  = cor_tx_done_valid;
            b.addr  = cor_tx_wr_addr;
            b.len   = cor_tx_wr_len;
            b.data  = cor_tx_data;
            b.cyc   = cyc;
            obs_q.push_back(b);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t make_beat(input logic f, input logic d, input logic [57:0] a,
                                        input logic [5:0] l, input logic [511:0] dat);
        beat_t b;
        b.fence = f;
        b.done  = d;
        b.addr  = a;
        b.len   = l;
        b.data  = dat;
        b.cyc   = 0;
        return b;
    endfunction

    task automatic compare_beats(input string tag);
        int n;
        check_output({tag, " beat count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_output({tag, " beat ctl"},
                         {obs_q[i].fence, obs_q[i].done, obs_q[i].addr, obs_q[i].len},
                         {exp_q[i].fence, exp_q[i].done, exp_q[i].addr, exp_q[i].len});
            check_output({tag, " beat data"}, obs_q[i].data, exp_q[i].data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Drives one job and appends the beats it should produce to exp_q.
    task automatic apply_stimulus(input logic [57:0] a, input logic [5:0] l, input logic de,
                                  input logic [63:0] dsm, input int stall_after, input int stall_len,
                                  input bit rand_mode, input int abort_at, output int acc_cyc);
        logic [511:0] lines[64];
        logic [511:0] payload;
        int  k;
        int  guard;
        int  stall_left;
        bit  hs;
        bit  af_now;
        for (int i = 0; i < l; i++)
            for (int j = 0; j < 16; j++) lines[i][j*32 +: 32] = $urandom;
        for (int i = 0; i < l; i++)
            exp_q.push_back(make_beat(1'b0, 1'b0, a + 58'(i), l, lines[i]));
        if (de) begin
            payload = '0;
            payload[31:0] = model_cnt + 32'd1;
            exp_q.push_back(make_beat(1'b1, 1'b0, 58'd0, 6'd1, 512'd0));
            exp_q.push_back(make_beat(1'b0, 1'b1, dsm[57:0], 6'd1, payload));
        end
        model_cnt = model_cnt + 32'd1;

        dsm_base_addr = dsm;
        job_valid     = 1'b1;
        job_addr      = a;
        job_len       = l;
        job_done_en   = de;
        guard         = 0;
        @(negedge clk);
        while (!job_ready && guard < 200) begin
            @(posedge clk); #1;
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check_output("job_ready timeout", 1'b0, 1'b1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        job_valid   = 1'b0;
        job_addr    = {$urandom, $urandom};
        job_len     = 6'($urandom);
        job_done_en = 1'($urandom);
        check_output("busy after accept", busy, (l != 6'd0) || de);
        check_output("job_ready after accept", job_ready, (l == 6'd0) && !de);

        k          = 0;
        guard      = 0;
        stall_left = stall_len;
        while (k < l && guard < 2000) begin
            af_now = (k == stall_after) && (stall_left > 0);
            if (af_now) stall_left--;
            if (rand_mode && $urandom_range(3) == 0) af_now = 1'b1;
            spl_tx_wr_almostfull = af_now;
            dat_valid = rand_mode ? ($urandom_range(3) != 0) : 1'b1;
            dat_data  = lines[k];
            @(negedge clk);
            check_output("dat_ready", dat_ready, !af_now);
            hs = dat_valid && dat_ready;
            @(posedge clk); #1;
            if (hs) k++;
            guard++;
            if (abort_at >= 0 && k == abort_at) break;
        end
        dat_valid            = 1'b0;
        spl_tx_wr_almostfull = 1'b0;
        if (guard >= 2000) check_output("data phase timeout", 1'b0, 1'b1);

        if (abort_at >= 0) begin
            @(negedge clk);
            #2 spl_reset = 1'b1;
            #1;
            check_output("abort strobes", {cor_tx_wr_valid, cor_tx_fence_valid, cor_tx_done_valid}, 3'b000);
            check_output("abort addr/len", {cor_tx_wr_addr, cor_tx_wr_len}, 64'd0);
            check_output("abort job_cnt", job_cnt, 0);
            check_output("abort busy/ready", {busy, job_ready}, 2'b01);
            #2 spl_reset = 1'b0;
            while (exp_q.size() > abort_at) void'(exp_q.pop_back());
            model_cnt = '0;
            @(posedge clk); #1;
            return;
        end

        guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            @(posedge clk); #1;
            spl_tx_wr_almostfull = rand_mode ? ($urandom_range(2) == 0) : 1'b0;
            @(negedge clk);
            guard++;
        end
        spl_tx_wr_almostfull = 1'b0;
        if (guard >= 200) check_output("idle timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        int          acc;
        int          b1;
        logic [57:0] ra;
        logic [5:0]  rl;
        spl_reset            = 1'b1;
        spl_tx_wr_almostfull = 1'b0;
        job_valid            = 1'b0;
        job_addr             = '0;
        job_len              = '0;
        job_done_en          = 1'b0;
        dat_valid            = 1'b0;
        dat_data             = '0;
        dsm_base_addr        = '0;
        model_cnt            = '0;

        tbl[0] = '{58'h1000, 6'd4, 1'b1, -1, 0, 64'h0000_0000_0000_2000, 6, 1};
        tbl[1] = '{58'h1000, 6'd4, 1'b1, 2, 3, 64'h0000_0000_0000_2000, 6, 2};
        tbl[2] = '{58'h0040, 6'd0, 1'b1, -1, 0, 64'hFFFF_0000_0000_3000, 2, 3};
        tbl[3] = '{58'h0080, 6'd0, 1'b0, -1, 0, 64'h0000_0000_0000_3000, 0, 4};
        tbl[4] = '{58'h0123, 6'd1, 1'b0, -1, 0, 64'h0000_0000_0000_3000, 1, 5};
        tbl[5] = '{58'h0200, 6'd3, 1'b1, -1, 0, 64'h0000_0000_0000_4440, 5, 6};
        tbl[6] = '{58'h3FF_FFFF_FFFF_FFFF, 6'd2, 1'b0, -1, 0, 64'h0000_0000_0000_5000, 2, 7};
        tbl[7] = '{58'h2BC_DEF0_1234_5678, 6'd63, 1'b1, -1, 0, 64'h0000_0000_0000_6000, 65, 8};

        repeat (3) @(posedge clk);
        #1;
        check_output("reset strobes", {cor_tx_wr_valid, cor_tx_fence_valid, cor_tx_done_valid, cor_tx_dsr_valid}, 4'b0000);
        check_output("reset addr/len", {cor_tx_wr_addr, cor_tx_wr_len}, 64'd0);
        check_output("reset data", cor_tx_data, 512'd0);
        check_output("reset job_cnt/busy", {job_cnt, busy}, 33'd0);
        spl_reset = 1'b0;
        #1;
        check_output("post-reset ready", {job_ready, dat_ready}, 2'b10);
        @(posedge clk); #1;

        $display("[TB] table-driven jobs");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(tbl[i].addr, tbl[i].len, tbl[i].done_en, tbl[i].dsm,
                           tbl[i].stall_after, tbl[i].stall_len, 1'b0, -1, acc);
            check_output($sformatf("table %0d strobe count", i), obs_q.size(), tbl[i].exp_beats);
            check_output($sformatf("table %0d job_cnt", i), job_cnt, tbl[i].exp_cnt);
            if (tbl[i].stall_after < 0 && obs_q.size() > 0) begin
                check_output($sformatf("table %0d first beat cycle", i), obs_q[0].cyc, acc + 2);
                for (int j = 1; j < obs_q.size(); j++)
                    check_output($sformatf("table %0d beat spacing", i), obs_q[j].cyc, obs_q[0].cyc + j);
            end
            compare_beats($sformatf("table %0d", i));
        end

        $display("[TB] reset in the middle of a job");
        apply_stimulus(58'h7000, 6'd5, 1'b1, 64'h8000, -1, 0, 1'b0, 2, acc);
        compare_beats("abort");

        $display("[TB] two jobs back to back after reset");
        apply_stimulus(58'h9000, 6'd1, 1'b0, 64'hA000, -1, 0, 1'b0, -1, acc);
        b1 = (obs_q.size() > 0) ? obs_q[0].cyc : 0;
        compare_beats("job A");
        apply_stimulus(58'h9100, 6'd3, 1'b1, 64'hA040, -1, 0, 1'b0, -1, acc);
        check_output("second accept not before first beat", acc >= b1, 1'b1);
        if (obs_q.size() > 0)
            check_output("second done payload", obs_q[obs_q.size()-1].data[31:0], 32'd2);
        else
            check_output("second done present", 1'b0, 1'b1);
        check_output("two-job job_cnt", job_cnt, 2);
        compare_beats("job B");

        $display("[TB] randomized jobs");
        for (int i = 0; i < 25; i++) begin
            ra = {$urandom, $urandom};
            if ($urandom_range(3) == 0) ra = 58'h3FF_FFFF_FFFF_FFFF - 58'($urandom_range(5));
            rl = ($urandom_range(4) == 0) ? 6'($urandom_range(63)) : 6'($urandom_range(8));
            apply_stimulus(ra, rl, 1'($urandom), {$urandom, $urandom}, -1, 0, 1'b1, -1, acc);
            check_output("random job_cnt", job_cnt, model_cnt);
            compare_beats("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
